// File: rtl/led_writer.sv
// led_writer: CPU-writable 24-bit LED port with registered readback.
// Optional blink engine is built only when LED_BLINK_EN is defined.
module led_writer #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        ledclk,
  input  logic        ledrst,
  input  logic        ledcs,
  input  logic [1:0]  ledaddr,
  input  logic        ledwrite,
  input  logic        ledread,
  input  logic [15:0] ledwdata,
  output logic [15:0] ledrdata,
  output logic [23:0] led_o
);

  logic        wr_en;
  logic        rd_en;
  logic        sel_lo;
  logic        sel_hi;
  logic        sel_mlo;
  logic        sel_mhi;
  logic [23:0] led;
  logic [23:0] bmask;
  logic        phase;
  logic [15:0] rd_mux;

  // a write on the same edge as a read takes priority
  assign wr_en   = ledcs & ledwrite;
  assign rd_en   = ledcs & ledread & ~ledwrite;

  assign sel_lo  = (ledaddr == 2'b00);
  assign sel_mlo = (ledaddr == 2'b01);
  assign sel_hi  = (ledaddr == 2'b10);
  assign sel_mhi = (ledaddr == 2'b11);

  // LED register: store data lands in the addressed field only
  always_ff @(posedge ledclk) begin
    if (!ledrst) begin
      led <= '0;
    end else if (wr_en && sel_lo) begin
      led[15:0] <= ledwdata;
    end else if (wr_en && sel_hi) begin
      led[23:16] <= ledwdata[7:0];
    end
  end

`ifdef LED_BLINK_EN
  localparam logic [25:0] DIV_LAST = 26'(BLINK_DIV - 1);

  logic [25:0] cnt;

  // blink mask: same field layout as the LED register
  always_ff @(posedge ledclk) begin
    if (!ledrst) begin
      bmask <= '0;
    end else if (wr_en && sel_mlo) begin
      bmask[15:0] <= ledwdata;
    end else if (wr_en && sel_mhi) begin
      bmask[23:16] <= ledwdata[7:0];
    end
  end

  // free-running half-period counter; mask writes never disturb it
  always_ff @(posedge ledclk) begin
    if (!ledrst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == DIV_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 26'd1;
    end
  end
`else
  // no blink engine: mask reads as zero, phase never asserts
  // for any legal divider
  assign bmask = '0;
  assign phase = (BLINK_DIV < 2);
`endif

  // readback mux; upper fields are zero-extended
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_lo:  rd_mux = led[15:0];
      sel_hi:  rd_mux = {8'd0, led[23:16]};
      sel_mlo: rd_mux = bmask[15:0];
      sel_mhi: rd_mux = {8'd0, bmask[23:16]};
      default: rd_mux = '0;
    endcase
  end

  // readback register holds unless a qualified read occurs
  always_ff @(posedge ledclk) begin
    if (!ledrst) begin
      ledrdata <= '0;
    end else if (rd_en) begin
      ledrdata <= rd_mux;
    end
  end

  // LED pins: masked LEDs forced off during the blink-off phase
  always_ff @(posedge ledclk) begin
    if (!ledrst) begin
      led_o <= '0;
    end else begin
      led_o <= led & ~(bmask & {24{phase}});
    end
  end

endmodule

// File: tb/tb_led_writer.sv
// tb_led_writer: directed scoreboard bench for led_writer.
// Blink checks are compiled only when LED_BLINK_EN is defined.
module tb_led_writer;

  logic        ledclk = 1'b0;
  logic        ledrst;
  logic        ledcs;
  logic [1:0]  ledaddr;
  logic        ledwrite;
  logic        ledread;
  logic [15:0] ledwdata;
  logic [15:0] ledrdata;
  logic [23:0] led_o;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_val[$];
  bit          exp_kind[$];
  string       exp_tag[$];

  led_writer #(.BLINK_DIV(4)) dut (
    .ledclk   (ledclk),
    .ledrst   (ledrst),
    .ledcs    (ledcs),
    .ledaddr  (ledaddr),
    .ledwrite (ledwrite),
    .ledread  (ledread),
    .ledwdata (ledwdata),
    .ledrdata (ledrdata),
    .led_o    (led_o)
  );

  always #5 ledclk = ~ledclk;

`ifdef LED_BLINK_EN
  logic [23:0] m_led = '0;
  logic [23:0] m_bm  = '0;
  int          m_cnt = 0;
  bit          m_ph  = 1'b0;

  function automatic logic [23:0] m_out();
    return m_led & ~(m_bm & {24{m_ph}});
  endfunction

  task automatic model(input logic r, input logic c, input logic w,
                       input logic [1:0] a, input logic [15:0] d);
    if (!r) begin
      m_led = '0;
      m_bm  = '0;
      m_cnt = 0;
      m_ph  = 1'b0;
    end else begin
      if (c && w) begin
        case (a)
          2'b00: m_led[15:0]  = d;
          2'b10: m_led[23:16] = d[7:0];
          2'b01: m_bm[15:0]   = d;
          default: m_bm[23:16] = d[7:0];
        endcase
      end
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_ph  = ~m_ph;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask
`endif

  task automatic step(input logic r, input logic c, input logic w,
                      input logic rd, input logic [1:0] a,
                      input logic [15:0] d);
    @(negedge ledclk);
    ledrst   = r;
    ledcs    = c;
    ledwrite = w;
    ledread  = rd;
    ledaddr  = a;
    ledwdata = d;
    @(posedge ledclk);
    #1;
`ifdef LED_BLINK_EN
    model(r, c, w, a, d);
`endif
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
  endtask

  task automatic exp_led(input logic [23:0] v, input string t);
    exp_val.push_back(v);
    exp_kind.push_back(1'b0);
    exp_tag.push_back(t);
  endtask

  task automatic exp_rd(input logic [15:0] v, input string t);
    exp_val.push_back({8'd0, v});
    exp_kind.push_back(1'b1);
    exp_tag.push_back(t);
  endtask

  task automatic chk();
    logic [23:0] v;
    logic [23:0] obs;
    bit          k;
    string       t;
    while (exp_val.size() > 0) begin
      v   = exp_val.pop_front();
      k   = exp_kind.pop_front();
      t   = exp_tag.pop_front();
      obs = k ? {8'd0, ledrdata} : led_o;
      tests++;
      assert (obs === v) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, v);
      end
    end
  endtask

  initial begin
    ledrst   = 1'b0;
    ledcs    = 1'b0;
    ledaddr  = 2'b00;
    ledwrite = 1'b0;
    ledread  = 1'b0;
    ledwdata = 16'h0000;

    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF);
    exp_led(24'h000000, "rst_led");
    exp_rd(16'h0000, "rst_rd");
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF);
    chk();

    idle();

    exp_led(24'h000000, "wr_lat0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hA5C3);
    chk();
    exp_led(24'h00A5C3, "wr_lo");
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 16'h7E99);
    chk();
    exp_led(24'h99A5C3, "wr_hi");
    idle();
    chk();

    exp_rd(16'h0099, "rd_hi");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0000);
    chk();
    exp_rd(16'hA5C3, "rd_lo");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000);
    chk();
    exp_rd(16'h0000, "rd_mask0");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0000);
    chk();
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000);

    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h1234);
    exp_led(24'h99A5C3, "cs_wr");
    idle();
    chk();
    exp_rd(16'hA5C3, "cs_rd");
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 16'h0000);
    chk();

    exp_rd(16'hA5C3, "coll_rd");
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0F0F);
    chk();
    exp_led(24'h990F0F, "coll_led");
    idle();
    chk();
    exp_rd(16'h0F0F, "coll_back");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000);
    chk();

    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 16'hFF12);
    exp_led(24'h120F0F, "hi_ign");
    idle();
    chk();
    exp_rd(16'h0012, "rd_hi_ign");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0000);
    chk();

`ifndef LED_BLINK_EN
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 16'h00FF);
    exp_led(24'h120F0F, "nob_led");
    idle();
    chk();
    exp_rd(16'h0000, "nob_rd01");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0000);
    chk();
    exp_rd(16'h0012, "nob_rdhi");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0000);
    chk();
    exp_rd(16'h0000, "nob_rd11");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0000);
    chk();
`else
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 16'h00FF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 16'h00FF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0000);
    exp_rd(16'h00FF, "bm_rd");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0000);
    chk();
    for (int i = 0; i < 12; i++) begin
      exp_led(m_out(), "blink");
      idle();
      chk();
    end
    exp_led(24'h000000, "blink_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    chk();
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 16'h00FF);
    for (int i = 0; i < 10; i++) begin
      exp_led(m_out(), "blink_re");
      idle();
      chk();
    end
`endif

    exp_led(24'h000000, "rst2_led");
    exp_rd(16'h0000, "rst2_rd");
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'hBEEF);
    chk();
    idle();
    exp_rd(16'h0000, "rst2_back");
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000);
    chk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
